// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and constants for the register-file write-back arbiter
// Contents: XZR (hard-wired zero register index), wb_entry_t (queued load result),
// arb_state_t (arbiter FSM state).
package wb_pkg;

  localparam logic [4:0] XZR = 5'd31;

  typedef struct packed {
    logic        valid;
    logic [4:0]  wa;
    logic [63:0] wd;
  } wb_entry_t;

  typedef enum logic {
    NORMAL = 1'b0,
    DRAIN  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - producer/register-file/decode signal bundle for wb_arbiter
// Signals: ALU handshake (alu_valid/alu_ready/alu_wa/alu_wd), load handshake
// (ld_valid/ld_ready/ld_wa/ld_wd), write port (we3/wa3/wd3), decode lookup
// (ra1/ra2 -> pend1/pend2), FIFO occupancy (count).
// Optional macro WB_FWD_EN adds fwd1/fwd2 (youngest queued load data per read address).
// Modports: slave = arbiter side, master = producer/consumer side.
interface wb_arbiter_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          alu_valid;
  logic          alu_ready;
  logic [4:0]    alu_wa;
  logic [63:0]   alu_wd;
  logic          ld_valid;
  logic          ld_ready;
  logic [4:0]    ld_wa;
  logic [63:0]   ld_wd;
  logic          we3;
  logic [4:0]    wa3;
  logic [63:0]   wd3;
  logic [4:0]    ra1;
  logic [4:0]    ra2;
  logic          pend1;
  logic          pend2;
  logic [CW-1:0] count;
`ifdef WB_FWD_EN
  logic [63:0]   fwd1;
  logic [63:0]   fwd2;
`endif

  modport slave (
    input  alu_valid, alu_wa, alu_wd, ld_valid, ld_wa, ld_wd, ra1, ra2,
    output alu_ready, ld_ready, we3, wa3, wd3, pend1, pend2, count
`ifdef WB_FWD_EN
    , output fwd1, fwd2
`endif
  );

  modport master (
    output alu_valid, alu_wa, alu_wd, ld_valid, ld_wa, ld_wd, ra1, ra2,
    input  alu_ready, ld_ready, we3, wa3, wd3, pend1, pend2, count
`ifdef WB_FWD_EN
    , input fwd1, fwd2
`endif
  );

endinterface

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - load-result circular buffer with kill-by-address and read-address match
// Ports: clk/reset; push_i/push_wa_i/push_wd_i enqueue; pop_i dequeue head_o;
// kill_i/kill_wa_i invalidate queued entries to a register; ra1_i/ra2_i -> pend1_o/pend2_o;
// count_o occupancy. Macro WB_FWD_EN adds fwd1_o/fwd2_o (youngest matching data).
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic [4:0]    push_wa_i,
  input  logic [63:0]   push_wd_i,
  input  logic          pop_i,
  input  logic          kill_i,
  input  logic [4:0]    kill_wa_i,
  input  logic [4:0]    ra1_i,
  input  logic [4:0]    ra2_i,
  output wb_entry_t     head_o,
  output logic [CW-1:0] count_o,
  output logic          pend1_o,
`ifdef WB_FWD_EN
  output logic [63:0]   fwd1_o,
  output logic [63:0]   fwd2_o,
`endif
  output logic          pend2_o
);

  wb_entry_t     mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [CW-1:0] count_q;

  // valid is cleared on pop, so a set valid bit always means an occupied slot;
  // the match logic below can then ignore the pointers entirely.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_i && mem_q[i].wa == kill_wa_i) mem_q[i].valid <= 1'b0;
      end
      if (pop_i) begin
        mem_q[rd_q].valid <= 1'b0;
        rd_q              <= rd_q + PW'(1);
      end
      // The push slot is never occupied (no push when full), so it may override the above.
      if (push_i) begin
        mem_q[wr_q] <= '{valid: 1'b1, wa: push_wa_i, wd: push_wd_i};
        wr_q        <= wr_q + PW'(1);
      end
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;

  always_comb begin
    pend1_o = 1'b0;
    pend2_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem_q[i].valid && mem_q[i].wa == ra1_i && ra1_i != XZR) pend1_o = 1'b1;
      if (mem_q[i].valid && mem_q[i].wa == ra2_i && ra2_i != XZR) pend2_o = 1'b1;
    end
  end

`ifdef WB_FWD_EN
  logic [PW-1:0] age_idx;

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    fwd1_o  = '0;
    fwd2_o  = '0;
    age_idx = rd_q;
    for (int i = 0; i < DEPTH; i++) begin
      age_idx = rd_q + PW'(i);
      if (mem_q[age_idx].valid && mem_q[age_idx].wa == ra1_i && ra1_i != XZR)
        fwd1_o = mem_q[age_idx].wd;
      if (mem_q[age_idx].valid && mem_q[age_idx].wa == ra2_i && ra2_i != XZR)
        fwd2_o = mem_q[age_idx].wd;
    end
  end
`endif

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - merges ALU and queued load results onto the register-file write port
// Ports: clk, reset (async, active-high), wb (wb_arbiter_if.slave: ALU/load handshakes,
// we3/wa3/wd3 write port, ra1/ra2 -> pend1/pend2, count).
// Parameters: DEPTH (load FIFO entries, power of two >= 2), STARVE_LIMIT (ALU wins
// against a waiting load before one forced drain cycle).
// Macro WB_FWD_EN adds fwd1/fwd2 forwarding outputs.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input logic           clk,
  input logic           reset,
  wb_arbiter_if.slave   wb
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  arb_state_t    state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          we3_q, we3_d;
  logic [4:0]    wa3_q, wa3_d;
  logic [63:0]   wd3_q, wd3_d;

  wb_entry_t     head;
  logic [CW-1:0] count;
  logic          fifo_empty;
  logic          alu_take;
  logic          pop;
  logic          push;
  logic          kill;

  assign fifo_empty = (count == '0);
  assign alu_take   = wb.alu_valid && (state_q == NORMAL);
  assign pop        = !fifo_empty && ((state_q == DRAIN) || !wb.alu_valid);
  // XZR loads are acknowledged but dropped here.
  assign push       = wb.ld_valid && wb.ld_ready && (wb.ld_wa != XZR);
  // An accepted ALU result is younger than any queued load to the same register.
  assign kill       = alu_take && (wb.alu_wa != XZR);

  assign wb.alu_ready = (state_q == NORMAL);
  assign wb.ld_ready  = (count < CW'(DEPTH));
  assign wb.count     = count;
  assign wb.we3       = we3_q;
  assign wb.wa3       = wa3_q;
  assign wb.wd3       = wd3_q;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (push),
    .push_wa_i (wb.ld_wa),
    .push_wd_i (wb.ld_wd),
    .pop_i     (pop),
    .kill_i    (kill),
    .kill_wa_i (wb.alu_wa),
    .ra1_i     (wb.ra1),
    .ra2_i     (wb.ra2),
    .head_o    (head),
    .count_o   (count),
    .pend1_o   (wb.pend1),
`ifdef WB_FWD_EN
    .fwd1_o    (wb.fwd1),
    .fwd2_o    (wb.fwd2),
`endif
    .pend2_o   (wb.pend2)
  );

  always_comb begin
    we3_d    = 1'b0;
    wa3_d    = wa3_q;
    wd3_d    = wd3_q;
    starve_d = starve_q;
    state_d  = state_q;

    // wa3/wd3 only move on a real write; XZR and killed entries leave them alone.
    if (alu_take) begin
      if (wb.alu_wa != XZR) begin
        we3_d = 1'b1;
        wa3_d = wb.alu_wa;
        wd3_d = wb.alu_wd;
      end
    end else if (pop && head.valid) begin
      we3_d = 1'b1;
      wa3_d = head.wa;
      wd3_d = head.wd;
    end

    if (state_q == DRAIN) begin
      starve_d = '0;
      state_d  = NORMAL;
    end else if (pop) begin
      starve_d = '0;
    end else if (alu_take && !fifo_empty) begin
      starve_d = starve_q + SW'(1);
      if (starve_d == SW'(STARVE_LIMIT)) state_d = DRAIN;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= NORMAL;
      starve_q <= '0;
      we3_q    <= 1'b0;
      wa3_q    <= XZR;
      wd3_q    <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      we3_q    <= we3_d;
      wa3_q    <= wa3_d;
      wd3_q    <= wd3_d;
    end
  end

endmodule
